// File: rtl/alu_seq_if.sv
// Handshake bundle between the control unit and alu_seq: a valid/ready operation request
// and a valid/ready result with NZCV flags and an illegal-op error bit.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    logic             err;

    modport master (
        output in_valid, op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out, flags, err
    );

    modport slave (
        input  in_valid, op, in_a, in_b, out_ready,
        output in_ready, out_valid, out, flags, err
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with NZCV flags, illegal-op error and an iterative shift-add multiplier
// that retires one multiplier bit per cycle.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic   CLK,
    input logic   reset_n,
    alu_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SL  = 4'd6;
    localparam logic [3:0] OP_SR  = 4'd7;
    localparam logic [3:0] OP_GT  = 4'd8;
    localparam logic [3:0] OP_LT  = 4'd9;
    localparam logic [3:0] OP_EQ  = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [3:0]         flags_q, flags_d;
    logic               err_q, err_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_err;
    logic [2*WIDTH-1:0] acc_step;

    assign bus.in_ready  = (state_q == IDLE) | ((state_q == HOLD) & bus.out_ready);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out       = out_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;

    assign accept   = bus.in_valid & bus.in_ready;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle ops, evaluated on the live inputs and only registered at accept.
    always_comb begin
        sum     = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        diff    = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_OR:  alu_res = bus.in_a | bus.in_b;
            OP_AND: alu_res = bus.in_a & bus.in_b;
            OP_XOR: alu_res = bus.in_a ^ bus.in_b;
            OP_SL:  alu_res = (bus.in_b >= SHIFT_LIM) ? '0 : (bus.in_a << bus.in_b);
            OP_SR:  alu_res = (bus.in_b >= SHIFT_LIM) ? '0 : (bus.in_a >> bus.in_b);
            OP_GT:  alu_res = {{(WIDTH-1){1'b0}}, bus.in_a > bus.in_b};
            OP_LT:  alu_res = {{(WIDTH-1){1'b0}}, bus.in_a < bus.in_b};
            OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, bus.in_a == bus.in_b};
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        flags_d  = flags_q;
        err_d    = err_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                    out_d   = acc_step[WIDTH-1:0];
                    flags_d = {acc_step[WIDTH-1], acc_step[WIDTH-1:0] == '0,
                               |acc_step[2*WIDTH-1:WIDTH], 1'b0};
                    err_d   = 1'b0;
                end
            end
            default: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        state_d  = MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, bus.in_a};
                        mplier_d = bus.in_b;
                        cnt_d    = '0;
                    end else begin
                        state_d = HOLD;
                        out_d   = alu_res;
                        err_d   = alu_err;
                        // Illegal ops report all-zero flags, not Z=1.
                        flags_d = alu_err ? 4'b0000 :
                                  {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                    end
                end else if (state_q == HOLD && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH=16, plus hand-written sequences for
// result backpressure, same-edge transfer/accept and reset in the middle of a multiply.
module tb_alu_seq;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    alu_seq_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .CLK     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        logic [3:0]  exp_flags;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [3:0] op, logic [15:0] a, logic [15:0] b,
                                logic [15:0] eo, logic [3:0] ef, logic ee, int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.exp_out = eo; v.exp_flags = ef; v.exp_err = ee; v.exp_lat = lat;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // Issue one op from IDLE, scramble the operands after accept, wait for the result.
    task automatic run_vec(vec_t v);
        int   lat;
        logic idle_in_busy;
        @(negedge clk);
        bus.op = v.op; bus.in_a = v.a; bus.in_b = v.b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a = ~v.a; bus.in_b = ~v.b; bus.op = 4'd1;
        lat = 1;
        idle_in_busy = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) idle_in_busy = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({v.name, " latency"}, lat, v.exp_lat);
        check({v.name, " out"}, {16'h0, bus.out}, {16'h0, v.exp_out});
        check({v.name, " flags"}, {28'h0, bus.flags}, {28'h0, v.exp_flags});
        check({v.name, " err"}, {31'h0, bus.err}, {31'h0, v.exp_err});
        if (v.exp_lat > 1) check({v.name, " in_ready low while busy"}, {31'h0, idle_in_busy}, 0);
        pop_result();
    endtask

    initial begin
        logic stable_bad;
        logic ready_bad;
        logic valid_seen;
        int   lat;
        n_checks = 0;
        n_fail   = 0;

        // flags are {N,Z,C,V}
        vecs.push_back(mk("add_wrap", 4'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 1'b0, 1));
        vecs.push_back(mk("add_ovf",  4'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0, 1));
        vecs.push_back(mk("sub_ovf",  4'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0, 1));
        vecs.push_back(mk("sub_brw",  4'd2, 16'h0001, 16'h0002, 16'hFFFF, 4'b1010, 1'b0, 1));
        vecs.push_back(mk("or",       4'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1'b0, 1));
        vecs.push_back(mk("and",      4'd4, 16'hF0F0, 16'hFF00, 16'hF000, 4'b1000, 1'b0, 1));
        vecs.push_back(mk("sl16",     4'd6, 16'h0001, 16'd16,   16'h0000, 4'b0100, 1'b0, 1));
        vecs.push_back(mk("sl4",      4'd6, 16'h0003, 16'd4,    16'h0030, 4'b0000, 1'b0, 1));
        vecs.push_back(mk("sr15",     4'd7, 16'h8000, 16'd15,   16'h0001, 4'b0000, 1'b0, 1));
        vecs.push_back(mk("gt",       4'd8, 16'h8000, 16'h0001, 16'h0001, 4'b0000, 1'b0, 1));
        vecs.push_back(mk("lt",       4'd9, 16'h0001, 16'h8000, 16'h0001, 4'b0000, 1'b0, 1));
        vecs.push_back(mk("eq_t",     4'd10, 16'h1234, 16'h1234, 16'h0001, 4'b0000, 1'b0, 1));
        vecs.push_back(mk("eq_f",     4'd10, 16'h1234, 16'h1235, 16'h0000, 4'b0100, 1'b0, 1));
        vecs.push_back(mk("mul",      4'd11, 16'h0123, 16'h0045, 16'h4E6F, 4'b0000, 1'b0, 17));
        vecs.push_back(mk("mul_hi",   4'd11, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 1'b0, 17));
        vecs.push_back(mk("mul_ff",   4'd11, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 1'b0, 17));
        vecs.push_back(mk("mul_sm",   4'd11, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0, 17));
        vecs.push_back(mk("ill13",    4'd13, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b1, 1));
        vecs.push_back(mk("ill0",     4'd0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 1'b1, 1));

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = 4'd0; bus.in_a = '0; bus.in_b = '0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset out_valid", {31'h0, bus.out_valid}, 0);
        check("reset out", {16'h0, bus.out}, 0);
        check("reset flags", {28'h0, bus.flags}, 0);
        check("reset err", {31'h0, bus.err}, 0);
        check("reset in_ready", {31'h0, bus.in_ready}, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: result must stay put for 5 cycles with in_ready low.
        @(negedge clk);
        bus.op = 4'd1; bus.in_a = 16'd1; bus.in_b = 16'd1; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        stable_bad = 1'b0; ready_bad = 1'b0;
        repeat (5) begin
            if (!bus.out_valid || bus.out !== 16'd2 || bus.flags !== 4'b0000 || bus.err !== 1'b0)
                stable_bad = 1'b1;
            if (bus.in_ready) ready_bad = 1'b1;
            @(negedge clk);
        end
        check("hold stable", {31'h0, stable_bad}, 0);
        check("hold in_ready low", {31'h0, ready_bad}, 0);

        // Same-edge transfer and new accept.
        bus.out_ready = 1'b1;
        bus.op = 4'd1; bus.in_a = 16'd2; bus.in_b = 16'd3; bus.in_valid = 1'b1;
        #1;
        check("hold in_ready w/ out_ready", {31'h0, bus.in_ready}, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("b2b out_valid", {31'h0, bus.out_valid}, 1);
        check("b2b out", {16'h0, bus.out}, 16'h0005);
        pop_result();

        // Reset during the multiply: nothing may come out afterwards.
        bus.op = 4'd11; bus.in_a = 16'h0123; bus.in_b = 16'h0045; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        bus.op = 4'd1; bus.in_a = 16'd7; bus.in_b = 16'd7; bus.in_valid = 1'b1;
        #1;
        check("midmul reset out_valid", {31'h0, bus.out_valid}, 0);
        check("midmul reset out", {16'h0, bus.out}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
        check("reset ignores input", {31'h0, bus.out_valid}, 0);
        check("midmul reset idle", {31'h0, bus.in_ready}, 1);
        valid_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) valid_seen = 1'b1;
        end
        check("no result after abort", {31'h0, valid_seen}, 0);

        bus.op = 4'd5; bus.in_a = 16'hF0F0; bus.in_b = 16'hFF00; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("xor after reset latency", lat, 1);
        check("xor after reset out", {16'h0, bus.out}, 16'h0FF0);
        pop_result();
        check("idle after pop", {31'h0, bus.out_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
